universal_ff_bank: RTL and testbench

Parametrised bank of `WIDTH` independent flip-flop channels. Each channel is built on a single synchronous D register, and a runtime `mode` input selects D, T, SR or JK next-state behaviour. It is the successor to the single-bit D-based SR flip-flop and adds three things:
- a configurable policy for the forbidden SR input S=R=1;
- a sticky error flag and a saturating error counter;
- a common enable.

It sits in the sequential-primitives library and is used wherever a control word needs per-bit set/reset/toggle semantics.

---
 rtl/ff_bank_pkg.sv | 10 +
 rtl/universal_ff_bank_cell.sv | 30 +++
 rtl/universal_ff_bank.sv | 49 ++++
 tb/tb_universal_ff_bank.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: mode encodings and forbidden-SR policy constants for universal_ff_bank
package ff_bank_pkg;
  localparam logic [1:0] MODE_D = 2'b00;
  localparam logic [1:0] MODE_T = 2'b01;
  localparam logic [1:0] MODE_SR = 2'b10;
  localparam logic [1:0] MODE_JK = 2'b11;
  localparam int SR_HOLD = 0;
  localparam int SR_SET_DOM = 1;
  localparam int SR_RST_DOM = 2;
endpackage

// File: rtl/universal_ff_bank_cell.sv
// ff_cell: one D register with a D/T/SR/JK next-state mux and forbidden-SR detect
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter int SR_POLICY = SR_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       q_bit,
  output logic       collide
);
  logic q_q, q_d, sr_both;
  always_comb begin
    sr_both = SR_POLICY == SR_SET_DOM ? 1'b1 : SR_POLICY == SR_RST_DOM ? 1'b0 : q_q;
    q_d = mode == MODE_D ? a :
          mode == MODE_T ? q_q ^ a :
          (a & b) ? (mode == MODE_JK ? ~q_q : sr_both) :
          a ? 1'b1 : b ? 1'b0 : q_q;
  end
  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else if (en) q_q <= q_d;
  end
  assign q_bit = q_q;
  assign collide = en & (mode == MODE_SR) & a & b;
endmodule

// File: rtl/universal_ff_bank.sv
// universal_ff_bank: WIDTH mode-selectable flip-flops with sticky SR error flag and saturating counter
module universal_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SR_POLICY = SR_HOLD,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sr_err,
  output logic [CNT_W-1:0] err_cnt
);
  logic [WIDTH-1:0] collide;
  logic             evt, sr_err_q, sr_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(.SR_POLICY(SR_POLICY)) u_cell (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a[i]), .b(b[i]),
      .q_bit(q[i]), .collide(collide[i])
    );
  end
  // A clear coinciding with an event restarts the count at one so the event is not lost
  always_comb begin
    evt = |collide;
    sr_err_d = evt | (~err_clr & sr_err_q);
    err_cnt_d = err_clr ? CNT_W'(evt) :
                (evt && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (en) begin
      sr_err_q <= sr_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign qn = ~q;
  assign sr_err = sr_err_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_universal_ff_bank.sv
// tb_universal_ff_bank: scoreboard bench for three policy variants against a behavioural model
module tb_universal_ff_bank;
  logic clk = 1'b0;
  logic rst, en, err_clr;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic [2:0][7:0] q, qn;
  logic [2:0] sr_err;
  logic [2:0][2:0] err_cnt;
  int checks = 0, errors = 0;

  typedef struct {
    logic [2:0][7:0] q;
    logic [2:0] err;
    logic [2:0][2:0] cnt;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mq[3];
  bit merr[3];
  int mcnt[3];

  always #5 clk = ~clk;

  for (genvar p = 0; p < 3; p++) begin : g_dut
    universal_ff_bank #(.WIDTH(8), .SR_POLICY(p), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q[p]), .qn(qn[p]), .sr_err(sr_err[p]), .err_cnt(err_cnt[p])
    );
  end

  task automatic step(input bit r, input bit e, input int md, input logic [7:0] ai,
                      input logic [7:0] bi, input bit clr);
    exp_t x;
    bit ev;
    @(negedge clk);
    rst = r; en = e; mode = md[1:0]; a = ai; b = bi; err_clr = clr;
    ev = e && md == 2 && (ai & bi) != 0;
    for (int p = 0; p < 3; p++) begin
      if (r) begin
        mq[p] = 0; merr[p] = 0; mcnt[p] = 0;
      end else if (e) begin
        for (int k = 0; k < 8; k++) begin
          bit s, c, o, n;
          s = ai[k]; c = bi[k]; o = mq[p][k];
          case (md)
            0: n = s;
            1: n = o ^ s;
            2: n = (s && c) ? (p == 1 ? 1'b1 : p == 2 ? 1'b0 : o) : s ? 1'b1 : c ? 1'b0 : o;
            default: n = (s && c) ? !o : s ? 1'b1 : c ? 1'b0 : o;
          endcase
          mq[p][k] = n;
        end
        if (clr) begin
          merr[p] = ev; mcnt[p] = ev ? 1 : 0;
        end else begin
          merr[p] = merr[p] || ev;
          if (ev && mcnt[p] < 7) mcnt[p]++;
        end
      end
      x.q[p] = mq[p]; x.err[p] = merr[p]; x.cnt[p] = 3'(mcnt[p]);
    end
    sb.push_back(x);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        for (int p = 0; p < 3; p++) begin
          checks++;
          if (q[p] !== x.q[p]) begin
            errors++; $display("FAIL q[pol%0d] got %h exp %h", p, q[p], x.q[p]);
          end
          checks++;
          if (qn[p] !== ~x.q[p]) begin
            errors++; $display("FAIL qn[pol%0d] got %h exp %h", p, qn[p], ~x.q[p]);
          end
          checks++;
          if (sr_err[p] !== x.err[p]) begin
            errors++; $display("FAIL sr_err[pol%0d] got %b exp %b", p, sr_err[p], x.err[p]);
          end
          checks++;
          if (err_cnt[p] !== x.cnt[p]) begin
            errors++; $display("FAIL err_cnt[pol%0d] got %0d exp %0d", p, err_cnt[p], x.cnt[p]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1; en = 0; mode = 0; a = 0; b = 0; err_clr = 0;
    step(1, 1, 0, 8'hFF, 8'h00, 0);
    step(1, 1, 0, 8'hFF, 8'h00, 0);
    step(0, 1, 0, 8'hFF, 8'h00, 0);
    step(0, 1, 0, 8'h00, 8'h00, 0);
    step(0, 1, 2, 8'h0F, 8'h00, 0);
    step(0, 1, 2, 8'h00, 8'h03, 0);
    step(0, 1, 2, 8'h00, 8'h00, 0);
    step(0, 1, 2, 8'h05, 8'h05, 0);
    step(0, 1, 0, 8'h0C, 8'h00, 1);
    step(0, 1, 3, 8'hFF, 8'hFF, 0);
    step(0, 1, 3, 8'hFF, 8'hFF, 0);
    step(0, 1, 0, 8'h00, 8'h00, 0);
    repeat (3) step(0, 1, 1, 8'h01, 8'h00, 0);
    step(0, 0, 2, 8'hFF, 8'hFF, 0);
    step(0, 1, 2, 8'h80, 8'h80, 0);
    step(0, 1, 2, 8'h01, 8'h01, 1);
    repeat (10) step(0, 1, 2, 8'hFF, 8'h81, 0);
    step(0, 0, 2, 8'hFF, 8'hFF, 0);
    step(0, 1, 0, 8'h00, 8'h00, 1);
    step(0, 1, 2, 8'hAA, 8'h55, 0);
    step(1, 1, 2, 8'hFF, 8'hFF, 0);
    for (int n = 0; n < 400; n++) begin
      bit e;
      e = $urandom_range(0, 9) < 8;
      step($urandom_range(0, 49) == 0, e, int'($urandom_range(0, 3)), 8'($urandom),
           8'($urandom), e && $urandom_range(0, 9) == 0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL drain pending %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
